// File: rtl/fwd_hazard_unit_if.sv
// Signal bundle between the pipeline (master) and the EX-stage forwarding and
// hazard unit (slave): consumer operands, producer stages, scoreboard events, results.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  logic                             ex_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0]    ex_rs_addr;
  logic [NUM_SRC-1:0]               ex_rs_used;
  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_rd;
  logic [NUM_STAGES-1:0]            stage_wr_en;
  logic [NUM_STAGES-1:0]            stage_rdy;
  logic                             lat_issue;
  logic [REG_ADDR_W-1:0]            lat_issue_rd;
  logic                             lat_done;
  logic [REG_ADDR_W-1:0]            lat_done_rd;
  logic                             clr_cnt;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel;
  logic                             stall;
  logic [2**REG_ADDR_W-1:0]         pending;
  logic [CNT_W-1:0]                 stall_cnt;
  logic [CNT_W-1:0]                 fwd_cnt;

  modport master (
    output ex_valid, ex_rs_addr, ex_rs_used, stage_rd, stage_wr_en, stage_rdy,
           lat_issue, lat_issue_rd, lat_done, lat_done_rd, clr_cnt,
    input  fwd_sel, stall, pending, stall_cnt, fwd_cnt
  );

  modport slave (
    input  ex_valid, ex_rs_addr, ex_rs_used, stage_rd, stage_wr_en, stage_rdy,
           lat_issue, lat_issue_rd, lat_done, lat_done_rd, clr_cnt,
    output fwd_sel, stall, pending, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding and hazard unit: nearest-stage operand forwarding, load-use and
// long-latency scoreboard stalls, and saturating stall/forward event counters.
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int SEL_W    = $clog2(NUM_STAGES + 1);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int FN_W     = $clog2(NUM_SRC + 1);

  logic [NUM_REGS-1:0]      pending_q, pending_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]         fwd_cnt_q, fwd_cnt_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [NUM_SRC-1:0]       hazard;
  logic [REG_ADDR_W-1:0]    rs;
  logic [REG_ADDR_W-1:0]    stage_rd_k;
  logic                     found;
  logic [FN_W-1:0]          fwd_num;
  logic [CNT_W:0]           fwd_sum;
  logic                     stall;

  // A stage match outranks the scoreboard: the in-pipe write is younger than the long-latency one.
  always_comb begin
    fwd_sel    = '0;
    hazard     = '0;
    fwd_num    = '0;
    rs         = '0;
    stage_rd_k = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs    = bus.ex_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      found = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_rd_k = bus.stage_rd[k*REG_ADDR_W +: REG_ADDR_W];
        if (!found && bus.ex_rs_used[i] && bus.stage_wr_en[k] &&
            stage_rd_k != '0 && stage_rd_k == rs) begin
          found                      = 1'b1;
          fwd_sel[i*SEL_W +: SEL_W]  = SEL_W'(k + 1);
          hazard[i]                  = !bus.stage_rdy[k];
        end
      end
      if (!found && bus.ex_rs_used[i] && rs != '0 && pending_q[rs])
        hazard[i] = 1'b1;
      if (found)
        fwd_num = fwd_num + FN_W'(1);
    end
  end

  assign stall = bus.ex_valid && (|hazard) && !rst;

  // Same-edge issue and done on one register: the issue is applied last so it wins.
  always_comb begin
    pending_d = pending_q;
    if (bus.lat_done)
      pending_d[bus.lat_done_rd] = 1'b0;
    if (bus.lat_issue)
      pending_d[bus.lat_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    fwd_sum     = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_num);
    if (bus.clr_cnt) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      if (bus.ex_valid && stall && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (bus.ex_valid && !stall)
        fwd_cnt_d = fwd_sum[CNT_W] ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall     = stall;
  assign bus.pending   = pending_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (2 src/2 stages/4-bit counters and
// 3 src/3 stages/8-bit counters) share one directed stimulus and one reference model.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       ex_valid;
  logic [4:0] rs [3];
  logic [2:0] used;
  logic [4:0] srd [3];
  logic [2:0] swr;
  logic [2:0] srdy;
  logic       lat_issue, lat_done, clr_cnt;
  logic [4:0] lat_issue_rd, lat_done_rd;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  checking    = 1'b0;

  bit  model_pend [32];
  int  m_stall_cnt [2];
  int  m_fwd_cnt [2];

  fwd_hazard_unit_if #(.NUM_SRC(2), .NUM_STAGES(2), .REG_ADDR_W(5), .CNT_W(4)) bus_a ();
  fwd_hazard_unit_if #(.NUM_SRC(3), .NUM_STAGES(3), .REG_ADDR_W(5), .CNT_W(8)) bus_b ();

  assign bus_a.ex_valid     = ex_valid;
  assign bus_a.ex_rs_addr   = {rs[1], rs[0]};
  assign bus_a.ex_rs_used   = used[1:0];
  assign bus_a.stage_rd     = {srd[1], srd[0]};
  assign bus_a.stage_wr_en  = swr[1:0];
  assign bus_a.stage_rdy    = srdy[1:0];
  assign bus_a.lat_issue    = lat_issue;
  assign bus_a.lat_issue_rd = lat_issue_rd;
  assign bus_a.lat_done     = lat_done;
  assign bus_a.lat_done_rd  = lat_done_rd;
  assign bus_a.clr_cnt      = clr_cnt;

  assign bus_b.ex_valid     = ex_valid;
  assign bus_b.ex_rs_addr   = {rs[2], rs[1], rs[0]};
  assign bus_b.ex_rs_used   = used;
  assign bus_b.stage_rd     = {srd[2], srd[1], srd[0]};
  assign bus_b.stage_wr_en  = swr;
  assign bus_b.stage_rdy    = srdy;
  assign bus_b.lat_issue    = lat_issue;
  assign bus_b.lat_issue_rd = lat_issue_rd;
  assign bus_b.lat_done     = lat_done;
  assign bus_b.lat_done_rd  = lat_done_rd;
  assign bus_b.clr_cnt      = clr_cnt;

  fwd_hazard_unit #(.NUM_SRC(2), .NUM_STAGES(2), .REG_ADDR_W(5), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  fwd_hazard_unit #(.NUM_SRC(3), .NUM_STAGES(3), .REG_ADDR_W(5), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Reference rules: nearest writing stage with the same nonzero register wins.
  function automatic int exp_sel(int n_stg, int i);
    if (!used[i] || rs[i] == 5'd0) return 0;
    for (int k = 0; k < n_stg; k++)
      if (swr[k] && srd[k] == rs[i]) return k + 1;
    return 0;
  endfunction

  function automatic bit exp_stall(int n_src, int n_stg);
    bit h = 1'b0;
    if (!ex_valid || rst) return 1'b0;
    for (int i = 0; i < n_src; i++) begin
      int s = exp_sel(n_stg, i);
      if (s != 0) begin
        if (!srdy[s-1]) h = 1'b1;
      end else if (used[i] && rs[i] != 5'd0 && model_pend[rs[i]]) begin
        h = 1'b1;
      end
    end
    return h;
  endfunction

  function automatic int exp_fwd_num(int n_src, int n_stg);
    int n = 0;
    for (int i = 0; i < n_src; i++)
      if (exp_sel(n_stg, i) != 0) n++;
    return n;
  endfunction

  always @(posedge clk) begin : model_update
    bit st;
    int n_src, cmax;
    for (int d = 0; d < 2; d++) begin
      n_src = (d == 0) ? 2 : 3;
      cmax  = (d == 0) ? 15 : 255;
      st    = exp_stall(n_src, n_src);
      if (rst || clr_cnt) begin
        m_stall_cnt[d] = 0;
        m_fwd_cnt[d]   = 0;
      end else begin
        if (ex_valid && st)
          m_stall_cnt[d] = (m_stall_cnt[d] + 1 > cmax) ? cmax : m_stall_cnt[d] + 1;
        if (ex_valid && !st)
          m_fwd_cnt[d] = (m_fwd_cnt[d] + exp_fwd_num(n_src, n_src) > cmax) ?
                         cmax : m_fwd_cnt[d] + exp_fwd_num(n_src, n_src);
      end
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) model_pend[r] = 1'b0;
    end else begin
      if (lat_done && lat_done_rd != 5'd0)   model_pend[lat_done_rd]  = 1'b0;
      if (lat_issue && lat_issue_rd != 5'd0) model_pend[lat_issue_rd] = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [63:0] e_sel_a, e_sel_b, e_pend;
    if (checking) begin
      e_sel_a = '0;
      e_sel_b = '0;
      e_pend  = '0;
      for (int i = 0; i < 2; i++) e_sel_a = e_sel_a | (64'(exp_sel(2, i)) << (2*i));
      for (int i = 0; i < 3; i++) e_sel_b = e_sel_b | (64'(exp_sel(3, i)) << (2*i));
      for (int r = 0; r < 32; r++) e_pend[r] = model_pend[r];
      checkOutput("A.fwd_sel",   64'(bus_a.fwd_sel),   e_sel_a);
      checkOutput("A.stall",     64'(bus_a.stall),     64'(exp_stall(2, 2)));
      checkOutput("A.pending",   64'(bus_a.pending),   e_pend);
      checkOutput("A.stall_cnt", 64'(bus_a.stall_cnt), 64'(m_stall_cnt[0]));
      checkOutput("A.fwd_cnt",   64'(bus_a.fwd_cnt),   64'(m_fwd_cnt[0]));
      checkOutput("B.fwd_sel",   64'(bus_b.fwd_sel),   e_sel_b);
      checkOutput("B.stall",     64'(bus_b.stall),     64'(exp_stall(3, 3)));
      checkOutput("B.pending",   64'(bus_b.pending),   e_pend);
      checkOutput("B.stall_cnt", 64'(bus_b.stall_cnt), 64'(m_stall_cnt[1]));
      checkOutput("B.fwd_cnt",   64'(bus_b.fwd_cnt),   64'(m_fwd_cnt[1]));
    end
  end

  task automatic idleInputs();
    ex_valid = 1'b0; used = '0; swr = '0; srdy = '1;
    lat_issue = 1'b0; lat_issue_rd = '0; lat_done = 1'b0; lat_done_rd = '0;
    clr_cnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs[i]  = '0;
      srd[i] = '0;
    end
  endtask

  // Let the currently driven inputs span n clock edges, then return just after the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    idleInputs();
    applyStimulus(2);
    rst = 1'b0;
    checking = 1'b1;
    sampleNow();
    checkOutput("reset.stall",     64'(bus_a.stall),     64'd0);
    checkOutput("reset.pending",   64'(bus_a.pending),   64'd0);
    checkOutput("reset.stall_cnt", 64'(bus_a.stall_cnt), 64'd0);
    checkOutput("reset.fwd_cnt",   64'(bus_a.fwd_cnt),   64'd0);

    // Forward priority
    applyStimulus(1);
    ex_valid = 1'b1; rs[0] = 5'd5; used = 3'b001;
    srd[0] = 5'd5; srd[1] = 5'd5; swr = 3'b011; srdy = 3'b111;
    sampleNow();
    checkOutput("prio.A.sel0", 64'(bus_a.fwd_sel[1:0]), 64'd1);
    checkOutput("prio.A.stall", 64'(bus_a.stall), 64'd0);
    checkOutput("prio.B.sel0", 64'(bus_b.fwd_sel[1:0]), 64'd1);
    applyStimulus(1);
    swr = 3'b010;
    sampleNow();
    checkOutput("prio.A.sel0_stage1", 64'(bus_a.fwd_sel[1:0]), 64'd2);
    applyStimulus(1);
    srd[0] = 5'd0; srd[1] = 5'd0; swr = 3'b011;
    sampleNow();
    checkOutput("prio.A.sel0_rd0", 64'(bus_a.fwd_sel[1:0]), 64'd0);
    applyStimulus(1);
    srd[2] = 5'd5; swr = 3'b100;
    sampleNow();
    checkOutput("gen.B.sel0_stage2", 64'(bus_b.fwd_sel[1:0]), 64'd3);
    checkOutput("gen.A.sel0_none",   64'(bus_a.fwd_sel[1:0]), 64'd0);

    // Load-use after clearing counters
    applyStimulus(1);
    idleInputs();
    clr_cnt = 1'b1;
    applyStimulus(1);
    clr_cnt = 1'b0;
    ex_valid = 1'b1; rs[1] = 5'd7; used = 3'b010;
    srd[0] = 5'd7; swr = 3'b001; srdy = 3'b110;
    sampleNow();
    checkOutput("lu.A.stall", 64'(bus_a.stall), 64'd1);
    checkOutput("lu.A.sel1",  64'(bus_a.fwd_sel[3:2]), 64'd1);
    applyStimulus(1);
    srdy = 3'b111;
    sampleNow();
    checkOutput("lu.A.stall_release", 64'(bus_a.stall), 64'd0);
    checkOutput("lu.A.stall_cnt",     64'(bus_a.stall_cnt), 64'd1);
    applyStimulus(1);
    ex_valid = 1'b0; swr = '0;
    sampleNow();
    checkOutput("lu.A.fwd_cnt", 64'(bus_a.fwd_cnt), 64'd1);
    checkOutput("lu.B.fwd_cnt", 64'(bus_b.fwd_cnt), 64'd1);
    applyStimulus(1);
    ex_valid = 1'b1; rs[2] = 5'd12; used = 3'b100;
    srd[2] = 5'd12; swr = 3'b100; srdy = 3'b011;
    sampleNow();
    checkOutput("gen.B.stall", 64'(bus_b.stall), 64'd1);
    checkOutput("gen.B.sel2",  64'(bus_b.fwd_sel[5:4]), 64'd3);
    checkOutput("gen.A.stall", 64'(bus_a.stall), 64'd0);

    // Scoreboard: issue r9, read r9 for cycles 1..4, done in cycle 4
    applyStimulus(1);
    idleInputs();
    lat_issue = 1'b1; lat_issue_rd = 5'd9;
    sampleNow();
    checkOutput("sb.pending9_c0", 64'(bus_a.pending[9]), 64'd0);
    applyStimulus(1);
    lat_issue = 1'b0;
    ex_valid = 1'b1; rs[0] = 5'd9; used = 3'b001;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        lat_done = 1'b1; lat_done_rd = 5'd9;
      end
      sampleNow();
      checkOutput($sformatf("sb.stall_c%0d", c), 64'(bus_a.stall), 64'd1);
      checkOutput($sformatf("sb.pending9_c%0d", c), 64'(bus_a.pending[9]), 64'd1);
      applyStimulus(1);
    end
    lat_done = 1'b0;
    sampleNow();
    checkOutput("sb.stall_c5",    64'(bus_a.stall), 64'd0);
    checkOutput("sb.pending9_c5", 64'(bus_a.pending[9]), 64'd0);

    // Simultaneous events and register 0
    applyStimulus(1);
    idleInputs();
    lat_issue = 1'b1; lat_issue_rd = 5'd3; lat_done = 1'b1; lat_done_rd = 5'd3;
    applyStimulus(1);
    lat_issue = 1'b0; lat_done_rd = 5'd3;
    sampleNow();
    checkOutput("sim.pending3", 64'(bus_a.pending), 64'h8);
    applyStimulus(1);
    lat_done = 1'b0;
    lat_issue = 1'b1; lat_issue_rd = 5'd0;
    applyStimulus(1);
    lat_issue = 1'b0;
    sampleNow();
    checkOutput("sim.pending_rd0", 64'(bus_a.pending), 64'h0);
    applyStimulus(1);
    lat_issue = 1'b1; lat_issue_rd = 5'd10;
    applyStimulus(1);
    lat_issue = 1'b0;
    ex_valid = 1'b1; rs[0] = 5'd10; used = 3'b001; srd[1] = 5'd10; swr = 3'b010;
    sampleNow();
    checkOutput("sim.match_pending10", 64'(bus_a.pending[10]), 64'd1);
    checkOutput("sim.match_nostall",   64'(bus_a.stall), 64'd0);
    checkOutput("sim.match_sel0",      64'(bus_a.fwd_sel[1:0]), 64'd2);
    applyStimulus(1);
    swr = 3'b000;
    sampleNow();
    checkOutput("sim.pending_stall", 64'(bus_a.stall), 64'd1);

    // Reset in the middle of a scoreboard stall
    applyStimulus(1);
    rst = 1'b1;
    sampleNow();
    checkOutput("rst.stall_now", 64'(bus_a.stall), 64'd0);
    applyStimulus(1);
    rst = 1'b0;
    sampleNow();
    checkOutput("rst.pending",   64'(bus_a.pending),   64'd0);
    checkOutput("rst.stall_cnt", 64'(bus_a.stall_cnt), 64'd0);
    checkOutput("rst.fwd_cnt",   64'(bus_a.fwd_cnt),   64'd0);
    checkOutput("rst.stall_off", 64'(bus_a.stall),     64'd0);

    // Counter saturation and clear priority
    applyStimulus(1);
    rs[0] = 5'd7; srd[0] = 5'd7; swr = 3'b001; srdy = 3'b000;
    applyStimulus(20);
    sampleNow();
    checkOutput("sat.A.stall_cnt", 64'(bus_a.stall_cnt), 64'd15);
    checkOutput("sat.B.stall_cnt", 64'(bus_b.stall_cnt), 64'd20);
    applyStimulus(1);
    clr_cnt = 1'b1;
    applyStimulus(1);
    clr_cnt = 1'b0;
    sampleNow();
    checkOutput("clr.A.stall_cnt", 64'(bus_a.stall_cnt), 64'd0);
    checkOutput("clr.B.stall_cnt", 64'(bus_b.stall_cnt), 64'd0);
    applyStimulus(1);
    sampleNow();
    checkOutput("clr.A.count_again", 64'(bus_a.stall_cnt), 64'd1);

    applyStimulus(1);
    idleInputs();
    applyStimulus(2);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
